// File: rtl/mem_access_controller.sv
// Sequences one MAR/MDR/memory transaction per control-unit request (Moore FSM).
// Latency: read WAIT_CYCLES+3, write WAIT_CYCLES+2 cycles from accept to DONE when memory is ready.
// Backpressure: requests are only sampled in IDLE; slow memory stretches the wait states up to TIMEOUT.
module mem_access_controller #(
    parameter int WAIT_CYCLES = 2,
    parameter int TIMEOUT     = 15
) (
    input  logic       MAC_clock,
    input  logic       MAC_reset,
    input  logic       MAC_req,
    input  logic       MAC_we,
    input  logic       MAC_mem_ready,
    output logic       MAC_busy,
    output logic       MAC_done,
    output logic       MAC_error,
    output logic       MAC_mar_load_en,
    output logic       MAC_mdr_bus_in_en,
    output logic       MAC_mdr_mem_in_en,
    output logic       MAC_mdr_bus_out_en,
    output logic       MAC_mem_read_en,
    output logic       MAC_mem_write_en,
    output logic [2:0] MAC_state
);

    localparam int CMAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
    localparam int CW   = (CMAX < 1) ? 1 : $clog2(CMAX + 1);
    localparam logic [CW-1:0] WAIT_C = CW'(WAIT_CYCLES);
    localparam logic [CW-1:0] TMO_C  = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        RWAIT = 3'd2,
        RCAP  = 3'd3,
        WWAIT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic          err_q, err_d;
    logic [CW-1:0] wcnt_q, wcnt_d;
    logic [CW-1:0] tcnt_q, tcnt_d;

    always_ff @(posedge MAC_clock) begin
        if (MAC_reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            wcnt_q  <= '0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            wcnt_q  <= wcnt_d;
            tcnt_q  <= tcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        err_d   = err_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;

        MAC_busy           = 1'b1;
        MAC_done           = 1'b0;
        MAC_error          = 1'b0;
        MAC_mar_load_en    = 1'b0;
        MAC_mdr_bus_in_en  = 1'b0;
        MAC_mdr_mem_in_en  = 1'b0;
        MAC_mdr_bus_out_en = 1'b0;
        MAC_mem_read_en    = 1'b0;
        MAC_mem_write_en   = 1'b0;

        case (state_q)
            IDLE: begin
                MAC_busy = 1'b0;
                if (MAC_req) begin
                    we_d    = MAC_we;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                MAC_mar_load_en   = 1'b1;
                MAC_mdr_bus_in_en = we_q;
                wcnt_d            = '0;
                tcnt_d            = '0;
                state_d           = we_q ? WWAIT : RWAIT;
            end
            RWAIT, WWAIT: begin
                MAC_mem_read_en  = (state_q == RWAIT);
                MAC_mem_write_en = (state_q == WWAIT);
                // Ready is only honoured once the minimum wait has saturated; ready beats timeout.
                if (wcnt_q != WAIT_C) begin
                    wcnt_d = wcnt_q + CW'(1);
                end else if (MAC_mem_ready) begin
                    state_d = (state_q == RWAIT) ? RCAP : DONE;
                end else if (tcnt_q == TMO_C) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    tcnt_d = tcnt_q + CW'(1);
                end
            end
            RCAP: begin
                MAC_mem_read_en   = 1'b1;
                MAC_mdr_mem_in_en = 1'b1;
                state_d           = DONE;
            end
            DONE: begin
                MAC_done           = 1'b1;
                MAC_error          = err_q;
                MAC_mdr_bus_out_en = !we_q && !err_q;
                err_d              = 1'b0;
                state_d            = IDLE;
            end
            default: begin
                MAC_busy = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign MAC_state = state_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Directed bench for mem_access_controller (WAIT_CYCLES=2, TIMEOUT=15) with hand-computed output vectors.
module tb_mem_access_controller;

    logic       MAC_clock = 1'b0;
    logic       MAC_reset = 1'b1;
    logic       MAC_req = 1'b0;
    logic       MAC_we = 1'b0;
    logic       MAC_mem_ready = 1'b1;
    logic       MAC_busy, MAC_done, MAC_error, MAC_mar_load_en, MAC_mdr_bus_in_en;
    logic       MAC_mdr_mem_in_en, MAC_mdr_bus_out_en, MAC_mem_read_en, MAC_mem_write_en;
    logic [2:0] MAC_state;

    mem_access_controller #(.WAIT_CYCLES(2), .TIMEOUT(15)) dut (
        .MAC_clock          (MAC_clock),
        .MAC_reset          (MAC_reset),
        .MAC_req            (MAC_req),
        .MAC_we             (MAC_we),
        .MAC_mem_ready      (MAC_mem_ready),
        .MAC_busy           (MAC_busy),
        .MAC_done           (MAC_done),
        .MAC_error          (MAC_error),
        .MAC_mar_load_en    (MAC_mar_load_en),
        .MAC_mdr_bus_in_en  (MAC_mdr_bus_in_en),
        .MAC_mdr_mem_in_en  (MAC_mdr_mem_in_en),
        .MAC_mdr_bus_out_en (MAC_mdr_bus_out_en),
        .MAC_mem_read_en    (MAC_mem_read_en),
        .MAC_mem_write_en   (MAC_mem_write_en),
        .MAC_state          (MAC_state)
    );

    always #5 MAC_clock = ~MAC_clock;

    // {busy, done, error, mar, mdr_bus_in, mdr_mem_in, mdr_bus_out, rd, wr, state[2:0]}
    logic [11:0] vec;
    assign vec = {MAC_busy, MAC_done, MAC_error, MAC_mar_load_en, MAC_mdr_bus_in_en,
                  MAC_mdr_mem_in_en, MAC_mdr_bus_out_en, MAC_mem_read_en, MAC_mem_write_en,
                  MAC_state};

    localparam logic [11:0] V_IDLE   = 12'h000;
    localparam logic [11:0] V_ADDR_R = 12'h901;
    localparam logic [11:0] V_ADDR_W = 12'h981;
    localparam logic [11:0] V_RWAIT  = 12'h812;
    localparam logic [11:0] V_RCAP   = 12'h853;
    localparam logic [11:0] V_WWAIT  = 12'h80C;
    localparam logic [11:0] V_DONE_R = 12'hC25;
    localparam logic [11:0] V_DONE_W = 12'hC05;
    localparam logic [11:0] V_DONE_E = 12'hE05;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    int addr_cnt = 0;

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge MAC_clock);
        #1;
    endtask

    // Memory strobes and the MDR bus driver are mutually exclusive every cycle.
    always @(negedge MAC_clock) begin
        check("excl", {11'b0, ($countones({MAC_mem_read_en, MAC_mem_write_en, MAC_mdr_bus_out_en}) <= 1)},
              12'd1);
        if (MAC_done) done_cnt++;
        if (MAC_state == 3'd1) addr_cnt++;
    end

    // Issue a one-cycle request; returns in cycle 1 (ADDR).
    task automatic start(input logic w);
        MAC_req = 1'b1;
        MAC_we  = w;
        tick();
        MAC_req = 1'b0;
    endtask

    task automatic run_read(input string tag);
        start(1'b0);
        check({tag, "_addr"}, vec, V_ADDR_R);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_rwait"}, vec, V_RWAIT);
        end
        tick();
        check({tag, "_rcap"}, vec, V_RCAP);
        tick();
        check({tag, "_done"}, vec, V_DONE_R);
        tick();
        check({tag, "_idle"}, vec, V_IDLE);
    endtask

    task automatic run_write(input string tag);
        start(1'b1);
        check({tag, "_addr"}, vec, V_ADDR_W);
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, "_wwait"}, vec, V_WWAIT);
        end
        tick();
        check({tag, "_done"}, vec, V_DONE_W);
        tick();
        check({tag, "_idle"}, vec, V_IDLE);
    endtask

    int base_done, base_addr;

    initial begin
        // Reset: outputs all zero in the cycle after the reset edge
        MAC_reset = 1'b1;
        tick();
        check("reset", vec, V_IDLE);
        tick();
        MAC_reset = 1'b0;
        tick();
        check("idle_noreq", vec, V_IDLE);

        run_read("rd");
        run_write("wr");

        // Late ready: RWAIT stretched by 5 cycles beyond saturation
        MAC_mem_ready = 1'b0;
        start(1'b0);
        check("late_addr", vec, V_ADDR_R);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("late_rwait", vec, V_RWAIT);
            if (i == 7) MAC_mem_ready = 1'b1;
        end
        tick();
        check("late_rcap", vec, V_RCAP);
        tick();
        check("late_done", vec, V_DONE_R);
        tick();
        check("late_idle", vec, V_IDLE);

        // Timeout on a write: 2 + 1 + 15 write cycles then error
        MAC_mem_ready = 1'b0;
        start(1'b1);
        check("tmo_addr", vec, V_ADDR_W);
        for (int i = 0; i < 18; i++) begin
            tick();
            check("tmo_wwait", vec, V_WWAIT);
        end
        tick();
        check("tmo_done_err", vec, V_DONE_E);
        tick();
        check("tmo_idle", vec, V_IDLE);
        MAC_mem_ready = 1'b1;
        run_write("post_tmo");

        // Reset in RWAIT cycle 2
        start(1'b0);
        tick();
        check("rst_rwait1", vec, V_RWAIT);
        tick();
        check("rst_rwait2", vec, V_RWAIT);
        MAC_reset = 1'b1;
        tick();
        check("rst_mid", vec, V_IDLE);
        MAC_reset = 1'b0;
        tick();
        check("rst_after", vec, V_IDLE);
        run_read("post_rst");

        // Back-to-back reads with req held high
        base_done = done_cnt;
        base_addr = addr_cnt;
        MAC_req = 1'b1;
        MAC_we  = 1'b0;
        tick();
        for (int t = 0; t < 2; t++) begin
            check("b2b_addr", vec, V_ADDR_R);
            for (int i = 0; i < 3; i++) begin
                tick();
                check("b2b_rwait", vec, V_RWAIT);
                MAC_we = (i == 1);
            end
            tick();
            check("b2b_rcap", vec, V_RCAP);
            tick();
            check("b2b_done", vec, V_DONE_R);
            MAC_we = 1'b0;
            if (t == 1) MAC_req = 1'b0;
            tick();
            check("b2b_gap_idle", vec, V_IDLE);
            tick();
        end
        check("b2b_stay_idle", vec, V_IDLE);
        check("b2b_counts", 12'(done_cnt - base_done), 12'(addr_cnt - base_addr));
        check("b2b_done_cnt", 12'(done_cnt - base_done), 12'd2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Moore FSM that sequences one memory transaction at a time through the MAR/MDR/memory datapath on behalf of the control unit.
- Read: load MAR, hold memory read through wait states, capture memory data into MDR, then drive MDR onto the bus for one cycle.
- Write: load MAR and MDR from the bus together, then hold memory write through wait states.
- Sits between the control unit's request/done handshake and the MAR, MDR and memory enable pins.

Parameters:
- WAIT_CYCLES, 2, minimum memory access cycles before mem_ready is honoured (0 allowed, which skips the minimum wait).
- TIMEOUT, 15, extra cycles allowed after the minimum wait for mem_ready before the access aborts with error (must be ≥1).

Ports:
- MAC_clock  input  1  system clock, all logic on the rising edge.
- MAC_reset  input  1  synchronous, active-high reset.
- MAC_req  input  1  transaction request, sampled only in IDLE.
- MAC_we  input  1  1 = write, 0 = read; sampled with MAC_req.
- MAC_mem_ready  input  1  memory completion strobe.
- MAC_busy  output  1  high in every state except IDLE.
- MAC_done  output  1  one-cycle completion pulse.
- MAC_error  output  1  high with MAC_done when the access timed out.
- MAC_mar_load_en  output  1  MAR loads its address from the bus.
- MAC_mdr_bus_in_en  output  1  MDR loads from the bus.
- MAC_mdr_mem_in_en  output  1  MDR loads from memory.
- MAC_mdr_bus_out_en  output  1  MDR tri-state drives the bus.
- MAC_mem_read_en  output  1  memory read strobe.
- MAC_mem_write_en  output  1  memory write strobe.
- MAC_state  output  3  state encoding, for debug.

Behaviour:
- State encodings: IDLE=0, ADDR=1, RWAIT=2, RCAP=3, WWAIT=4, DONE=5. Codes 6 and 7 go to IDLE on the next edge.
- All outputs decode from the state register and the registered error flag only; no input-to-output combinational path.
- Reset: state=IDLE, wait counter=0, timeout counter=0, error flag=0. Every output is 0 in the cycle after the reset edge.
- Reset wins over everything, including mid-transaction; no memory strobe survives past the reset edge.
- IDLE: when MAC_req=1 at an edge, latch MAC_we and go to ADDR. Otherwise stay.
- ADDR (1 cycle): MAC_mar_load_en=1. If the latched we=1, MAC_mdr_bus_in_en=1 in the same cycle. Next state is WWAIT (we=1) or RWAIT (we=0). Both counters clear.
- RWAIT: MAC_mem_read_en=1.
  - The wait counter counts up to WAIT_CYCLES, then saturates.
  - Once saturated, MAC_mem_ready=1 at an edge goes to RCAP.
  - Otherwise the timeout counter increments each edge. When it reaches TIMEOUT, set the error flag and go to DONE.
- RCAP (1 cycle): MAC_mem_read_en=1 and MAC_mdr_mem_in_en=1, then go to DONE.
- WWAIT: MAC_mem_write_en=1. Same counter, ready and timeout rules as RWAIT. Success goes directly to DONE.
- DONE (1 cycle): MAC_done=1 and MAC_error equals the error flag.
  - On a successful read only, MAC_mdr_bus_out_en=1.
  - Next state is IDLE and the error flag clears.
- MAC_req is ignored outside IDLE. A req held high through DONE starts a new transaction from IDLE on the following edge, so transactions are always separated by at least one IDLE cycle.
- MAC_mem_ready is ignored before the minimum wait completes and in every state other than RWAIT/WWAIT.
- Total latency, measured from the edge that accepts req to the first cycle of DONE with mem_ready already high:
  - Read: WAIT_CYCLES+3 cycles (ADDR + RWAIT of WAIT_CYCLES+1 cycles + RCAP).
  - Write: WAIT_CYCLES+2 cycles.
- With WAIT_CYCLES=0, mem_ready is honoured on the first wait cycle.
- Counter widths are sized to hold max(WAIT_CYCLES, TIMEOUT) and must never wrap.
- Never assert more than one of the following in the same cycle: MAC_mem_read_en, MAC_mem_write_en, MAC_mdr_bus_out_en. The bench asserts this every cycle.

Test Plan:
- Read, WAIT_CYCLES=2, mem_ready tied 1: req=1, we=0 for one cycle. Expect mar_load_en in cycle 1, mem_read_en in cycles 2-5, mdr_mem_in_en in cycle 5, done=1 with mdr_bus_out_en=1 and error=0 in cycle 6, busy=0 in cycle 7.
- Write, WAIT_CYCLES=2, mem_ready tied 1: expect mar_load_en and mdr_bus_in_en together in cycle 1, mem_write_en in cycles 2-4, done=1 with mdr_bus_out_en=0 in cycle 5.
- Late ready on a read: mem_ready rises 5 cycles after minimum-wait saturation. Expect RWAIT extended by exactly 5 cycles, then RCAP then DONE with error=0.
- Timeout on a write, mem_ready held 0, TIMEOUT=15: expect mem_write_en for WAIT_CYCLES+1+15 cycles, then done=1 with error=1. The next transaction's DONE shows error=0.
- Reset mid-read: assert reset during RWAIT cycle 2. Expect every output 0 on the next cycle and state=IDLE; a req issued after reset releases completes normally.
- Back-to-back requests with req held high through two reads: exactly one IDLE cycle between DONE and the next ADDR; req pulses during busy are ignored, so done count equals accepted count.
